// File: rtl/ghr_manager_pkg.sv
// Shared branch-predictor defines and helpers for the GHR manager slice.
// Holds the default history length / in-flight depth and the saturating counter helper.
`ifndef MAX_GHT_LENGTH
`define MAX_GHT_LENGTH 8
`endif
`ifndef GHR_BUS
`define GHR_BUS [`MAX_GHT_LENGTH-1:0]
`endif

package ghr_manager_pkg;

  localparam int unsigned GHR_LENGTH_DEF     = `MAX_GHT_LENGTH;
  localparam int unsigned INFLIGHT_DEPTH_DEF = 8;

  typedef logic [31:0] statCnt_t;

  localparam statCnt_t STAT_CNT_MAX = 32'hFFFF_FFFF;

  // Statistics counters stick at all-ones instead of wrapping back to zero.
  function automatic statCnt_t satInc(input statCnt_t value);
    return (value == STAT_CNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ghr_manager_inflight_fifo.sv
// In-flight branch store: 1-bit predicted directions, oldest first.
// Occupancy comes only from the counter; clear wins over push/pop.
module bpu_inflight_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic          head_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PW'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wrPtr_q] <= data_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ghr_manager.sv
// Speculative/committed global history manager with mispredict repair and flush recovery.
// Optional statistics counters are built only when GHR_MANAGER_STATS_EN is defined.
module ghr_manager
  import ghr_manager_pkg::*;
#(
  parameter  int unsigned GHR_LENGTH     = GHR_LENGTH_DEF,
  parameter  int unsigned INFLIGHT_DEPTH = INFLIGHT_DEPTH_DEF,
  localparam int unsigned CW             = $clog2(INFLIGHT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  predict_valid,
  input  logic                  predict_taken,
  output logic                  predict_ready,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  input  logic                  flush_i,
  output logic [GHR_LENGTH-1:0] global_history_o,
  output logic                  mispredict_o,
  output logic [CW-1:0]         inflight_count_o,
  output logic                  branch_valid_o,
  output logic                  branch_taken_o,
  output logic [31:0]           resolve_cnt_o,
  output logic [31:0]           mispredict_cnt_o
);

  logic [GHR_LENGTH-1:0] specGhr_q, specGhr_d;
  logic [GHR_LENGTH-1:0] archGhr_q, archGhr_d;
  logic                  mispredict_q, branchValid_q, branchTaken_q;
  logic [CW-1:0]         count;
  logic                  head;
  logic                  predAccept, resAccept, misPred, fifoClear;

  assign predict_ready = (count != CW'(INFLIGHT_DEPTH));
  assign predAccept    = predict_valid && predict_ready;
  assign resAccept     = resolve_valid && (count != '0);
  assign misPred       = resAccept && (resolve_taken != head);
  assign fifoClear     = flush_i || misPred;

  // Flush and repair both restore from the post-resolve committed history; a dropped predict never lands.
  always_comb begin
    archGhr_d = archGhr_q;
    specGhr_d = specGhr_q;
    if (resAccept) archGhr_d = {archGhr_q[GHR_LENGTH-2:0], resolve_taken};
    if (fifoClear)       specGhr_d = archGhr_d;
    else if (predAccept) specGhr_d = {specGhr_q[GHR_LENGTH-2:0], predict_taken};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      specGhr_q     <= '0;
      archGhr_q     <= '0;
      mispredict_q  <= 1'b0;
      branchValid_q <= 1'b0;
      branchTaken_q <= 1'b0;
    end else begin
      specGhr_q     <= specGhr_d;
      archGhr_q     <= archGhr_d;
      mispredict_q  <= misPred;
      branchValid_q <= resAccept;
      branchTaken_q <= resAccept && resolve_taken;
    end
  end

  bpu_inflight_fifo #(
    .DEPTH (INFLIGHT_DEPTH)
  ) u_inflightFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (predAccept && !fifoClear),
    .data_i  (predict_taken),
    .pop_i   (resAccept && !fifoClear),
    .clear_i (fifoClear),
    .head_o  (head),
    .count_o (count)
  );

`ifdef GHR_MANAGER_STATS_EN
  statCnt_t resolveCnt_q, mispredictCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resolveCnt_q    <= '0;
      mispredictCnt_q <= '0;
    end else begin
      if (resAccept) resolveCnt_q    <= satInc(resolveCnt_q);
      if (misPred)   mispredictCnt_q <= satInc(mispredictCnt_q);
    end
  end

  assign resolve_cnt_o    = resolveCnt_q;
  assign mispredict_cnt_o = mispredictCnt_q;
`else
  assign resolve_cnt_o    = 32'd0;
  assign mispredict_cnt_o = 32'd0;
`endif

  assign global_history_o = specGhr_q;
  assign mispredict_o     = mispredict_q;
  assign inflight_count_o = count;
  assign branch_valid_o   = branchValid_q;
  assign branch_taken_o   = branchTaken_q;

endmodule

// File: tb/tb_ghr_manager.sv
// Scoreboard bench for ghr_manager: directed vectors queue hand-computed post-edge
// expectations, and an independent monitor compares them after each rising edge.
module tb_ghr_manager;

  localparam int unsigned GL = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef GHR_MANAGER_STATS_EN
  localparam logic [31:0] EXP_RES_CNT = 32'd5;
  localparam logic [31:0] EXP_MIS_CNT = 32'd2;
`else
  localparam logic [31:0] EXP_RES_CNT = 32'd0;
  localparam logic [31:0] EXP_MIS_CNT = 32'd0;
`endif

  typedef struct {
    string          name;
    logic [GL-1:0]  ghr;
    logic [CW-1:0]  cnt;
    logic           ready;
    logic           misp;
    logic           bv;
    logic           bt;
  } expect_t;

  logic          clk;
  logic          rst;
  logic          predictValid, predictTaken, predictReady;
  logic          resolveValid, resolveTaken, flush;
  logic [GL-1:0] ghr;
  logic          mispredict;
  logic [CW-1:0] inflightCount;
  logic          branchValid, branchTaken;
  logic [31:0]   resolveCnt, mispredictCnt;

  expect_t sbQ[$];
  int      errors = 0;
  int      checks = 0;

  ghr_manager #(
    .GHR_LENGTH     (GL),
    .INFLIGHT_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .predict_valid    (predictValid),
    .predict_taken    (predictTaken),
    .predict_ready    (predictReady),
    .resolve_valid    (resolveValid),
    .resolve_taken    (resolveTaken),
    .flush_i          (flush),
    .global_history_o (ghr),
    .mispredict_o     (mispredict),
    .inflight_count_o (inflightCount),
    .branch_valid_o   (branchValid),
    .branch_taken_o   (branchTaken),
    .resolve_cnt_o    (resolveCnt),
    .mispredict_cnt_o (mispredictCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input string name, input logic pv, input logic pt, input logic rv,
                               input logic rt, input logic fl, input logic [GL-1:0] eGhr,
                               input logic [CW-1:0] eCnt, input logic eReady, input logic eMisp,
                               input logic eBv, input logic eBt);
    expect_t e;
    @(negedge clk);
    predictValid = pv;
    predictTaken = pt;
    resolveValid = rv;
    resolveTaken = rt;
    flush        = fl;
    e.name = name; e.ghr = eGhr; e.cnt = eCnt; e.ready = eReady;
    e.misp = eMisp; e.bv = eBv; e.bt = eBt;
    sbQ.push_back(e);
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 40 && sbQ.size() != 0; i++) @(negedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbQ.size());
    end
  endtask

  // Monitor: compare every queued expectation just after the edge it belongs to.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput({e.name, ".ghr"},   32'(ghr),           32'(e.ghr));
        checkOutput({e.name, ".cnt"},   32'(inflightCount), 32'(e.cnt));
        checkOutput({e.name, ".ready"}, 32'(predictReady),  32'(e.ready));
        checkOutput({e.name, ".misp"},  32'(mispredict),    32'(e.misp));
        checkOutput({e.name, ".bv"},    32'(branchValid),   32'(e.bv));
        checkOutput({e.name, ".bt"},    32'(branchTaken),   32'(e.bt));
      end
    end
  end

  initial begin
    rst = 1'b0;
    predictValid = 1'b0; predictTaken = 1'b0;
    resolveValid = 1'b0; resolveTaken = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset.ghr",   32'(ghr), 32'h0);
    checkOutput("reset.cnt",   32'(inflightCount), 32'h0);
    checkOutput("reset.ready", 32'(predictReady), 32'h1);
    checkOutput("reset.misp",  32'(mispredict), 32'h0);
    checkOutput("reset.bv",    32'(branchValid), 32'h0);
    checkOutput("reset.bt",    32'(branchTaken), 32'h0);
    checkOutput("reset.rcnt",  resolveCnt, 32'h0);
    checkOutput("reset.mcnt",  mispredictCnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    //              name        pv pt rv rt fl  ghr    cnt rdy ms bv bt
    applyStimulus("p1",         1, 1, 0, 0, 0, 8'h01, 1, 1, 0, 0, 0);
    applyStimulus("p2",         1, 0, 0, 0, 0, 8'h02, 2, 1, 0, 0, 0);
    applyStimulus("p3",         1, 1, 0, 0, 0, 8'h05, 3, 1, 0, 0, 0);
    applyStimulus("p4",         1, 1, 0, 0, 0, 8'h0B, 4, 1, 0, 0, 0);
    applyStimulus("p5",         1, 1, 0, 0, 0, 8'h17, 5, 1, 0, 0, 0);
    applyStimulus("p6",         1, 1, 0, 0, 0, 8'h2F, 6, 1, 0, 0, 0);
    applyStimulus("p7",         1, 1, 0, 0, 0, 8'h5F, 7, 1, 0, 0, 0);
    applyStimulus("p8full",     1, 1, 0, 0, 0, 8'hBF, 8, 0, 0, 0, 0);
    applyStimulus("pFullDrop",  1, 0, 0, 0, 0, 8'hBF, 8, 0, 0, 0, 0);
    applyStimulus("resOk",      0, 0, 1, 1, 0, 8'hBF, 7, 1, 0, 1, 1);
    applyStimulus("predResOk",  1, 1, 1, 0, 0, 8'h7F, 7, 1, 0, 1, 0);
    applyStimulus("predResBad", 1, 1, 1, 0, 0, 8'h04, 0, 1, 1, 1, 0);
    applyStimulus("resEmpty",   0, 0, 1, 1, 0, 8'h04, 0, 1, 0, 0, 0);
    applyStimulus("p9",         1, 1, 0, 0, 0, 8'h09, 1, 1, 0, 0, 0);
    applyStimulus("p10",        1, 0, 0, 0, 0, 8'h12, 2, 1, 0, 0, 0);
    applyStimulus("flushResOk", 1, 1, 1, 1, 1, 8'h09, 0, 1, 0, 1, 1);
    applyStimulus("p11",        1, 1, 0, 0, 0, 8'h13, 1, 1, 0, 0, 0);
    applyStimulus("flushResBad",0, 0, 1, 0, 1, 8'h12, 0, 1, 1, 1, 0);
    applyStimulus("idle1",      0, 0, 0, 0, 0, 8'h12, 0, 1, 0, 0, 0);
    drainQueue();
    checkOutput("stats.rcnt", resolveCnt, EXP_RES_CNT);
    checkOutput("stats.mcnt", mispredictCnt, EXP_MIS_CNT);

    applyStimulus("p12",        1, 1, 0, 0, 0, 8'h25, 1, 1, 0, 0, 0);
    applyStimulus("p13",        1, 1, 0, 0, 0, 8'h4B, 2, 1, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("asyncRst.ghr",   32'(ghr), 32'h0);
    checkOutput("asyncRst.cnt",   32'(inflightCount), 32'h0);
    checkOutput("asyncRst.ready", 32'(predictReady), 32'h1);
    checkOutput("asyncRst.rcnt",  resolveCnt, 32'h0);
    @(negedge clk);
    predictValid = 1'b0; predictTaken = 1'b0;
    resolveValid = 1'b0; resolveTaken = 1'b0; flush = 1'b0;
    rst = 1'b1;

    applyStimulus("p14",        1, 1, 0, 0, 0, 8'h01, 1, 1, 0, 0, 0);
    applyStimulus("p15",        1, 1, 0, 0, 0, 8'h03, 2, 1, 0, 0, 0);
    applyStimulus("repairZero", 0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0);
    applyStimulus("idle2",      0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    drainQueue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ghr_manager.md
GHR_MANAGER -- requirements
Module: ghr_manager

Interface
REQ-001 Parameter GHR_LENGTH, default `MAX_GHT_LENGTH; width of the global history register (GHR).
REQ-002 Parameter INFLIGHT_DEPTH, default 8 (power of two, ≥2); maximum number of unresolved predicted branches.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 predict_valid  input  1  the fetch stage issues a prediction this cycle.
REQ-006 predict_taken  input  1  predicted direction, i.e. the gshared predictor `taken` output.
REQ-007 predict_ready  output  1  a prediction can be accepted (FIFO not full).
REQ-008 resolve_valid  input  1  the oldest in-flight branch is resolved this cycle.
REQ-009 resolve_taken  input  1  actual direction of that branch.
REQ-010 flush_i  input  1  external pipeline flush (exception/ertn); discards all in-flight branches.
REQ-011 global_history_o  output  GHR_LENGTH  speculative GHR; drives `global_history_i` of gshared_predictor.
REQ-012 mispredict_o  output  1  one-cycle pulse: the resolved direction differed from the stored prediction.
REQ-013 inflight_count_o  output  $clog2(INFLIGHT_DEPTH)+1  number of unresolved branches.
REQ-014 branch_valid_o / branch_taken_o  output  1 / 1  registered copy of resolve_valid / resolve_taken; drives the predictor update port.
REQ-015 resolve_cnt_o, mispredict_cnt_o  output  32 / 32  statistics counters (see Configuration).

Function
REQ-016 The block SHALL hold two registers: spec_ghr (speculative, output) and arch_ghr (committed); shift direction: {ghr[GHR_LENGTH-2:0], bit}.
REQ-017 An accepted predict (predict_valid & predict_ready) SHALL shift predict_taken into spec_ghr and push predict_taken into the in-flight FIFO; global_history_o reflects it the next cycle.
REQ-018 predict_ready SHALL be 0 when inflight_count_o == INFLIGHT_DEPTH; a predict_valid while not ready SHALL be ignored with no state change.
REQ-019 An accepted resolve (resolve_valid & inflight_count_o != 0) SHALL pop the FIFO head and shift resolve_taken into arch_ghr.
REQ-020 resolve_valid while the FIFO is empty SHALL be ignored: no pop, no arch_ghr change, no pulse.
REQ-021 On an accepted resolve with resolve_taken != head, the block SHALL assert mispredict_o the next cycle, load spec_ghr with {arch_ghr[GHR_LENGTH-2:0], resolve_taken}, and clear the FIFO (count 0).
REQ-022 A simultaneous accepted predict and correct resolve SHALL both take effect; the count is unchanged.
REQ-023 A simultaneous predict and mispredicting resolve SHALL drop the predict (repair wins); the count becomes 0.
REQ-024 flush_i SHALL load spec_ghr with arch_ghr (including any same-cycle resolve shift), clear the FIFO, and take priority over predict; a same-cycle resolve still commits, and its mispredict pulse still fires.
REQ-025 FIFO pointers SHALL wrap modulo INFLIGHT_DEPTH; full/empty SHALL be derived from the count, never from pointer equality.
REQ-026 branch_valid_o SHALL be 1 only for accepted resolves, with one cycle of latency.

Reset
REQ-027 While rst is 0: spec_ghr = arch_ghr = 0, FIFO empty, inflight_count_o = 0, predict_ready = 1, mispredict_o = branch_valid_o = branch_taken_o = 0, counters = 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries immediately, independent of clk.

Configuration
REQ-029 With macro GHR_MANAGER_STATS_EN defined: resolve_cnt_o counts accepted resolves and mispredict_cnt_o counts mispredicts; both saturate at 32'hFFFF_FFFF.
REQ-030 Without GHR_MANAGER_STATS_EN: both counter outputs SHALL be tied to 0 and no counter flops synthesized; the port list is unchanged.

Structure
REQ-031 GHR_LENGTH default, INFLIGHT_DEPTH default, and the `GHR_BUS width macro SHALL live in the shared branch_predictor defines; nothing is module-local except derived widths.
REQ-032 The in-flight store SHALL be a sub-module, bpu_inflight_fifo (1-bit data, push/pop/clear, count output); the GHR logic stays in ghr_manager.

Verification
REQ-033 Reset, then 3 predicts (1,0,1) -> global_history_o = 'b101, inflight_count_o = 3.
REQ-034 Fill to 8 entries, then predict_valid=1 -> predict_ready = 0, GHR unchanged, count stays 8.
REQ-035 Predicts 1,1; resolve_taken=0 -> mispredict_o pulse, global_history_o = 'b0 (arch = 0 shifted with 0), count = 0.
REQ-036 Count = 2, predict_valid=1 with a correct resolve in the same cycle -> count remains 2; arch_ghr and spec_ghr each shift once.
REQ-037 resolve_valid while empty -> no pulse, branch_valid_o = 0, counters unchanged.
REQ-038 With GHR_MANAGER_STATS_EN: 5 resolves including 2 mispredicts -> resolve_cnt_o = 5, mispredict_cnt_o = 2; without the macro, both read 0.
